mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sits directly downstream of the instruction and data caches and upstream of the RAM model.
- Arbitrates single-word icache reads and dcache reads/writes (including two-word block fills and write-backs) onto one RAM port.
- Uses a registered grant FSM with round-robin fairness, a per-access timeout, and sticky error capture.
- Replaces the combinational memory controller; caches see the usual iwait/dwait semantics.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, word width
TIMEOUT, 64, max cycles a granted access may wait for RAM ACCESS before abort
ERR_WORD, 32'hBAD1BAD1, data returned on aborted or errored access

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous active-high reset
iREN  in  1  icache read request
iaddr  in  ADDR_W  icache word address
iwait  out  1  low for exactly one cycle when the icache access completes
iload  out  DATA_W  icache read data, valid when iwait low
dREN  in  1  dcache read request
dWEN  in  1  dcache write request
daddr  in  ADDR_W  dcache word address
dstore  in  DATA_W  dcache write data
dwait  out  1  low for exactly one cycle when the dcache access completes
dload  out  DATA_W  dcache read data, valid when dwait low
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  ADDR_W  RAM address
ramstore  out  DATA_W  RAM write data
ramload  in  DATA_W  RAM read data
ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
err  out  1  sticky; set on timeout or ERROR
err_addr  out  ADDR_W  address of the first failing access

Behaviour:
- Reset (synchronous, RST high at the edge):
  - state=IDLE, last_served=ICACHE, timer=0, err=0, err_addr=0.
  - All outputs take these values the cycle after the edge: iwait=1, dwait=1, ram enables 0, ramaddr 0, ramstore 0, iload 0, dload 0.
  - Reset mid-access abandons it silently: no completion pulse and no error.
- States and transitions:
  - IDLE: drives no RAM enables. Request evaluation:
    - Only d (dREN|dWEN) pending -> DGRANT.
    - Only iREN pending -> IGRANT.
    - Both pending -> the requester not equal to last_served.
    - No requests -> stay IDLE.
  - IGRANT: ramREN=1, ramaddr=iaddr.
  - DGRANT: ramaddr=daddr. If dWEN: ramWEN=1, ramstore=dstore, ramREN=0. Else ramREN=1. dWEN wins when dREN and dWEN are both high.
- Arbitration latency: one cycle from request to RAM enable. RAM signals are combinational from the registered state plus the live requester inputs.
- Completion, in a grant state when ramstate==ACCESS:
  - The granted requester's wait goes low that cycle; load = ramload.
  - timer clears; last_served updates.
  - If the same requester still asserts a request in that cycle, the grant holds (block bursts stay atomic). Otherwise next state is IDLE.
- Error, in a grant state when ramstate==ERROR:
  - Treated as completion with load=ERR_WORD.
  - err set; err_addr loaded only if err was 0.
- Timeout: timer increments on each grant cycle without ACCESS/ERROR. When timer==TIMEOUT-1 and no ACCESS:
  - Abort: wait low, load=ERR_WORD, error capture as above.
  - Next state IDLE regardless of request.
- Dropped request: requester drops its request while granted and before completion -> next state IDLE, no wait pulse, timer cleared.
- Non-granted side: wait=1, load=0, always.
- Fairness: a held dcache burst may hold for at most its request duration. On release, a pending icache request is granted next.
- Width: timer width is $clog2(TIMEOUT). No other arithmetic.

Decomposition:
- Shared package (cpu_types_pkg): ramstate_t; new arb_state_t {IDLE, IGRANT, DGRANT}; requester_t {ICACHE, DCACHE}.
- One sub-module: arb_timeout_counter. Inputs: clear, enable. Output: expire at TIMEOUT-1.

Test Plan:
- Isolated icache read, RAM returns ACCESS after 2 BUSY cycles, ramload=32'h1234ABCD:
  - ramREN rises 1 cycle after iREN.
  - iwait low exactly 1 cycle, with iload=32'h1234ABCD.
- iREN and dREN asserted together from reset:
  - DGRANT first (last_served=ICACHE).
  - After the dcache completes and drops its request, IGRANT.
  - icache never waits more than one dcache burst.
- dcache two-word write-back: dWEN held across addresses 0x40 then 0x44, dstore 0xAAAA0000 and 0xBBBB0000:
  - Both RAM writes occur with no intervening IGRANT, despite iREN held high.
- RAM stays BUSY forever on a read at 0x80 with TIMEOUT=64:
  - dwait low on cycle 64 of the grant, dload=32'hBAD1BAD1.
  - err=1, err_addr=0x80, state IDLE.
- ramstate=ERROR on icache read at 0x10, then a second ERROR at 0x20:
  - err=1, err_addr stays 0x10.
- RST high mid-DGRANT:
  - Next cycle: ram enables 0, dwait=1, err=0, IDLE.
  - No spurious completion pulse.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/RAM path: RAM handshake states and arbiter grant bookkeeping.
package cpu_types_pkg;

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} arb_state_t;
    typedef enum logic {ICACHE, DCACHE} requester_t;

    // On contention the side that was not served last goes first.
    function automatic arb_state_t pick_grant(input logic ireq, input logic dreq,
                                              input requester_t last);
        if (ireq && dreq) return (last == ICACHE) ? DGRANT : IGRANT;
        if (dreq)         return DGRANT;
        if (ireq)         return IGRANT;
        return IDLE;
    endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Counts grant cycles spent waiting on RAM; expire flags the last cycle before abort.
module arb_timeout_counter #(
    parameter int TIMEOUT = 64
) (
    input  logic CLK,
    input  logic RST,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear)       cnt_d = '0;
        else if (enable) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expire = (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter putting icache reads and dcache reads/writes onto one RAM port,
// with per-access timeout and sticky capture of the first failing address.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 64,
    parameter logic [DATA_W-1:0] ERR_WORD = 32'hBAD1BAD1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr
);
    arb_state_t        state_q, state_d;
    requester_t        last_q, last_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    ramstate_t         rs;
    logic              dreq, act, hit, done, bad, abort, expire;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] word;

    arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
        .CLK    (CLK),
        .RST    (RST),
        .clear  (!act || done),
        .enable (act && !done),
        .expire (expire)
    );

    always_comb begin
        rs       = ramstate_t'(ramstate);
        dreq     = dREN || dWEN;
        // A grant only counts as live while its owner keeps requesting.
        act      = ((state_q == IGRANT) && iREN) || ((state_q == DGRANT) && dreq);
        hit      = (rs == ACCESS);
        abort    = act && expire && !hit;
        done     = act && (hit || (rs == ERROR) || expire);
        bad      = done && !hit;
        word     = hit ? ramload : ERR_WORD;
        cur_addr = (state_q == DGRANT) ? daddr : iaddr;

        iwait    = 1'b1;
        iload    = '0;
        dwait    = 1'b1;
        dload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        state_d  = state_q;

        case (state_q)
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (done) begin
                    iwait = 1'b0;
                    iload = word;
                end
            end
            DGRANT: begin
                ramaddr = daddr;
                ramWEN  = dWEN;
                ramREN  = dREN && !dWEN;
                if (dWEN) ramstore = dstore;
                if (done) begin
                    dwait = 1'b0;
                    dload = word;
                end
            end
            default: ;
        endcase

        if (state_q == IDLE)     state_d = pick_grant(iREN, dreq, last_q);
        else if (!act || abort)  state_d = IDLE;

        last_d     = last_q;
        if (done) last_d = (state_q == DGRANT) ? DCACHE : ICACHE;
        err_d      = err_q || bad;
        err_addr_d = (bad && !err_q) ? cur_addr : err_addr_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            last_q     <= ICACHE;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            err_q      <= err_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign err      = err_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, all outputs compared every
// cycle against an ownership/wait-count reference model.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int          TIMEOUT = 64;
    localparam logic [31:0] ERRW    = 32'hBAD1BAD1;

    logic        CLK = 1'b0, RST = 1'b1;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [31:0] iaddr = '0, daddr = '0, dstore = '0, ramload = '0;
    logic [1:0]  ramstate = 2'(FREE);
    logic        iwait, dwait, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore, err_addr;

    mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err), .err_addr(err_addr)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who owns the port (0 none, 1 icache, 2 dcache), how long the
    // current access has waited, who was served last, and the sticky error record.
    int          m_own = 0, m_wait = 0;
    bit          m_lastd = 1'b0, m_err = 1'b0, mchk = 1'b0;
    logic [31:0] m_eaddr = '0;

    function automatic bit owner_active(input int own);
        if (own == 1) return iREN;
        if (own == 2) return dREN || dWEN;
        return 1'b0;
    endfunction

    always @(negedge CLK) if (mchk) begin
        automatic bit          fin;
        automatic logic [31:0] word, e_addr;
        fin    = owner_active(m_own) && (ramstate == 2'(ACCESS) || ramstate == 2'(ERROR) ||
                                         m_wait == TIMEOUT - 1);
        word   = (ramstate == 2'(ACCESS)) ? ramload : ERRW;
        e_addr = (m_own == 1) ? iaddr : (m_own == 2) ? daddr : 32'h0;
        chk("m_iwait",    iwait,    !(m_own == 1 && fin));
        chk("m_iload",    iload,    (m_own == 1 && fin) ? word : 32'h0);
        chk("m_dwait",    dwait,    !(m_own == 2 && fin));
        chk("m_dload",    dload,    (m_own == 2 && fin) ? word : 32'h0);
        chk("m_ramREN",   ramREN,   (m_own == 1) ? iREN : (m_own == 2) ? (dREN && !dWEN) : 1'b0);
        chk("m_ramWEN",   ramWEN,   m_own == 2 && dWEN);
        chk("m_ramaddr",  ramaddr,  e_addr);
        chk("m_ramstore", ramstore, (m_own == 2 && dWEN) ? dstore : 32'h0);
        chk("m_err",      err,      m_err);
        chk("m_err_addr", err_addr, m_eaddr);
    end

    always @(posedge CLK) begin
        automatic int          own = m_own, wt = m_wait;
        automatic bit          lastd = m_lastd, e = m_err;
        automatic logic [31:0] ea = m_eaddr;
        automatic bit          ireq = iREN, dreq = dREN || dWEN;
        if (RST) begin
            own = 0; wt = 0; lastd = 0; e = 0; ea = '0;
        end else if (m_own == 0) begin
            wt = 0;
            if (ireq && dreq) own = lastd ? 1 : 2;
            else if (dreq)    own = 2;
            else if (ireq)    own = 1;
        end else if (!owner_active(m_own)) begin
            own = 0; wt = 0;
        end else if (ramstate == 2'(ACCESS)) begin
            lastd = (m_own == 2); wt = 0;
        end else if (ramstate == 2'(ERROR) || m_wait == TIMEOUT - 1) begin
            lastd = (m_own == 2); wt = 0;
            if (!m_err) ea = (m_own == 2) ? daddr : iaddr;
            e = 1'b1;
            if (m_wait == TIMEOUT - 1) own = 0;
        end else begin
            wt = m_wait + 1;
        end
        m_own <= own; m_wait <= wt; m_lastd <= lastd; m_err <= e; m_eaddr <= ea;
    end

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic quiet();
        iREN = 0; dREN = 0; dWEN = 0; ramstate = 2'(FREE);
    endtask

    task automatic do_reset();
        quiet(); RST = 1; tick(); RST = 0;
    endtask

    initial begin
        int n;
        tick(); mchk = 1;
        RST = 0;
        @(negedge CLK);
        chk("rst_iwait", iwait, 1); chk("rst_dwait", dwait, 1);
        chk("rst_ramREN", ramREN, 0); chk("rst_err", err, 0);

        // Isolated icache read, two BUSY cycles then ACCESS.
        do_reset();
        iREN = 1; iaddr = 32'h100;
        @(negedge CLK); chk("t1_no_ren_yet", ramREN, 0);
        tick(); ramstate = 2'(BUSY);
        @(negedge CLK); chk("t1_ren", ramREN, 1); chk("t1_addr", ramaddr, 32'h100);
        tick();
        tick(); ramstate = 2'(ACCESS); ramload = 32'h1234ABCD;
        @(negedge CLK); chk("t1_iwait_lo", iwait, 0); chk("t1_iload", iload, 32'h1234ABCD);
        tick(); iREN = 0; ramstate = 2'(FREE);
        @(negedge CLK); chk("t1_iwait_hi", iwait, 1);

        // Simultaneous requests from reset: dcache first, icache right after.
        do_reset();
        iREN = 1; iaddr = 32'h300; dREN = 1; daddr = 32'h200;
        tick(); ramstate = 2'(ACCESS); ramload = 32'h55;
        @(negedge CLK); chk("t2_d_first", ramaddr, 32'h200); chk("t2_dwait", dwait, 0);
        tick(); dREN = 0; ramstate = 2'(FREE);
        tick();
        tick();
        @(negedge CLK); chk("t2_i_next", ramaddr, 32'h300); chk("t2_i_ren", ramREN, 1);
        tick(); quiet();

        // Two-word write-back stays atomic while icache waits.
        do_reset();
        iREN = 1; iaddr = 32'h500; dWEN = 1; daddr = 32'h40; dstore = 32'hAAAA0000;
        tick(); ramstate = 2'(ACCESS);
        @(negedge CLK); chk("t3_w0_wen", ramWEN, 1); chk("t3_w0_data", ramstore, 32'hAAAA0000);
        tick(); daddr = 32'h44; dstore = 32'hBBBB0000;
        @(negedge CLK);
        chk("t3_w1_wen", ramWEN, 1); chk("t3_w1_addr", ramaddr, 32'h44);
        chk("t3_w1_data", ramstore, 32'hBBBB0000); chk("t3_w1_no_ren", ramREN, 0);
        tick(); dWEN = 0; ramstate = 2'(FREE);
        tick();
        tick();
        @(negedge CLK); chk("t3_i_after", ramaddr, 32'h500);
        tick(); quiet();

        // RAM never answers: abort on the 64th grant cycle.
        do_reset();
        dREN = 1; daddr = 32'h80; ramstate = 2'(BUSY);
        tick();
        n = 1;
        while (n < 100) begin
            @(negedge CLK);
            if (dwait == 1'b0) break;
            tick(); n++;
        end
        chk("t4_cycle", n, TIMEOUT);
        chk("t4_dload", dload, ERRW);
        tick();
        @(negedge CLK);
        chk("t4_idle", ramREN, 0); chk("t4_err", err, 1); chk("t4_err_addr", err_addr, 32'h80);
        tick(); quiet();

        // Two RAM errors: only the first address is kept.
        do_reset();
        iREN = 1; iaddr = 32'h10;
        tick(); ramstate = 2'(ERROR);
        @(negedge CLK); chk("t5_iwait", iwait, 0); chk("t5_iload", iload, ERRW);
        tick(); iREN = 0; ramstate = 2'(FREE);
        tick(); iREN = 1; iaddr = 32'h20;
        tick(); ramstate = 2'(ERROR);
        tick(); quiet();
        @(negedge CLK); chk("t5_err", err, 1); chk("t5_err_addr", err_addr, 32'h10);

        // Reset in the middle of a dcache grant.
        do_reset();
        dREN = 1; daddr = 32'h90; ramstate = 2'(BUSY);
        tick();
        @(negedge CLK); chk("t6_granted", ramREN, 1);
        tick(); RST = 1;
        tick(); RST = 0;
        @(negedge CLK);
        chk("t6_ren", ramREN, 0); chk("t6_dwait", dwait, 1); chk("t6_err", err, 0);
        tick(); quiet();

        // Random traffic, with occasional long BUSY stretches and stray resets.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            automatic int r = $urandom_range(0, 99);
            if ($urandom_range(0, 3) == 0) iREN = ~iREN;
            if ($urandom_range(0, 3) == 0) dREN = $urandom_range(0, 1);
            if ($urandom_range(0, 4) == 0) dWEN = $urandom_range(0, 1);
            iaddr   = {$urandom_range(0, 63), 2'b00};
            daddr   = {$urandom_range(0, 63), 2'b00};
            dstore  = $urandom;
            ramload = $urandom;
            if ((c % 700) >= 600)  ramstate = 2'(BUSY);
            else if (r < 40)       ramstate = 2'(ACCESS);
            else if (r < 85)       ramstate = 2'(BUSY);
            else if (r < 90)       ramstate = 2'(ERROR);
            else                   ramstate = 2'(FREE);
            RST = ($urandom_range(0, 299) == 0);
            tick();
        end
        RST = 0; quiet();
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
